// File: rtl/sram_1p_rsp.sv
// Single-port SRAM back-end with per-word parity and post-reset array clear.
// Optional output register stage: define SRAM_1P_RSP_OUTREG_EN (read latency 2).
module sram_1p_rsp #(
  parameter int unsigned Aw = 12,
  parameter int unsigned Dw = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  input  logic [Aw-1:0] addr_i,
  input  logic          write_i,
  input  logic [Dw-1:0] wdata_i,
  input  logic          par_inj_i,
  output logic          rvalid_o,
  output logic [Dw-1:0] rdata_o,
  output logic [1:0]    rerror_o,
  output logic          init_done_o
);

  localparam int unsigned Depth = 2 ** Aw;

  localparam logic [0:0] INIT  = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]    state_q;
  logic [Aw-1:0] cnt_q;

  logic [Dw:0]   mem [Depth];
  logic          mem_we;
  logic [Aw-1:0] mem_waddr;
  logic [Dw:0]   mem_wdata;

  logic          rd_en;
  logic          rvalid_q;
  logic          rd_init_q;
  logic [Dw:0]   rd_word_q;

  logic          rsp_valid;
  logic [Dw-1:0] rsp_data;
  logic [1:0]    rsp_err;

  // INIT sweeps the array through the single write port; user writes are dropped meanwhile.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_i;
    mem_wdata = {(^wdata_i) ^ par_inj_i, wdata_i};
    if (state_q == INIT) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (req_i && write_i) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else if (state_q == INIT) begin
      cnt_q <= cnt_q + 1'b1;
      if (&cnt_q) begin
        state_q <= READY;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign rd_en = req_i && !write_i && (state_q == READY);

  always_ff @(posedge clk_i) begin
    if (rd_en) begin
      rd_word_q <= mem[addr_i];
    end
  end

  // Every read gets a response; reads taken during INIT answer zero data with an error.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_q  <= 1'b0;
      rd_init_q <= 1'b0;
    end else begin
      rvalid_q  <= req_i && !write_i;
      rd_init_q <= (state_q == INIT);
    end
  end

  always_comb begin
    rsp_valid = rvalid_q;
    rsp_data  = '0;
    rsp_err   = '0;
    if (rvalid_q) begin
      if (rd_init_q) begin
        rsp_err = 2'b10;
      end else begin
        rsp_data = rd_word_q[Dw-1:0];
        rsp_err  = {(^rd_word_q[Dw-1:0]) != rd_word_q[Dw], 1'b0};
      end
    end
  end

`ifdef SRAM_1P_RSP_OUTREG_EN
  logic          out_valid_q;
  logic [Dw-1:0] out_data_q;
  logic [1:0]    out_err_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= '0;
    end else begin
      out_valid_q <= rsp_valid;
      out_data_q  <= rsp_data;
      out_err_q   <= rsp_err;
    end
  end

  assign rvalid_o = rst_ni && out_valid_q;
  assign rdata_o  = rst_ni ? out_data_q : '0;
  assign rerror_o = rst_ni ? out_err_q : '0;
`else
  // Gating with rst_ni drops a response that is already visible when reset arrives.
  assign rvalid_o = rst_ni && rsp_valid;
  assign rdata_o  = rst_ni ? rsp_data : '0;
  assign rerror_o = rst_ni ? rsp_err : '0;
`endif

  assign init_done_o = rst_ni && (state_q == READY);

endmodule

// File: tb/tb_sram_1p_rsp.sv
// Self-checking bench for sram_1p_rsp (Aw=4) with an in-order response scoreboard.
module tb_sram_1p_rsp;

  localparam int AW  = 4;
  localparam int DW  = 32;
  localparam int DEP = 16;
`ifdef SRAM_1P_RSP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NEVER = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          req;
  logic [AW-1:0] addr;
  logic          write;
  logic [DW-1:0] wdata;
  logic          par_inj;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic [1:0]    rerror;
  logic          init_done;

  sram_1p_rsp #(.Aw(AW), .Dw(DW)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .req_i      (req),
    .addr_i     (addr),
    .write_i    (write),
    .wdata_i    (wdata),
    .par_inj_i  (par_inj),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .rerror_o   (rerror),
    .init_done_o(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
    logic [1:0]  err;
  } exp_t;

  exp_t          q[$];
  exp_t          mon_e;
  int            edge_cnt = 0;
  int            ready_edge = NEVER;
  int            errors = 0;
  int            checks = 0;
  bit            mon_en = 1'b0;
  logic [DW-1:0] mem_m [DEP];
  logic          par_m [DEP];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Scoreboard: each response must match the oldest outstanding read, on its due cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rvalid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_rvalid: edge=%0d rdata=%h rerror=%b, required no response", edge_cnt, rdata, rerror);
        end else begin
          mon_e = q.pop_front();
          if (rdata !== mon_e.data || rerror !== mon_e.err || edge_cnt !== mon_e.due) begin
            errors++;
            $display("FAIL read_rsp: got data=%h err=%b edge=%0d, required data=%h err=%b edge=%0d",
                     rdata, rerror, edge_cnt, mon_e.data, mon_e.err, mon_e.due);
          end
        end
      end else begin
        checks++;
        if (rdata !== '0 || rerror !== 2'b00) begin
          errors++;
          $display("FAIL idle_zero: rdata=%h rerror=%b while rvalid=0, required 0/00", rdata, rerror);
        end
        if (q.size() != 0 && q[0].due <= edge_cnt) begin
          mon_e = q.pop_front();
          errors++;
          $display("FAIL missing_rsp: no rvalid at edge %0d, required data=%h err=%b", mon_e.due, mon_e.data, mon_e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic inj);
    req = 1'b1; write = 1'b1; addr = AW'(a); wdata = d; par_inj = inj;
    if (edge_cnt + 1 > ready_edge) begin
      mem_m[a] = d;
      par_m[a] = (^d) ^ inj;
    end
    tick();
    req = 1'b0; write = 1'b0; par_inj = 1'b0;
  endtask

  task automatic rd(input int a, input bit push);
    exp_t e;
    req = 1'b1; write = 1'b0; addr = AW'(a);
    e.due = edge_cnt + LAT;
    if (edge_cnt + 1 > ready_edge) begin
      e.data = mem_m[a];
      e.err  = {(^mem_m[a]) != par_m[a], 1'b0};
    end else begin
      e.data = '0;
      e.err  = 2'b10;
    end
    if (push) q.push_back(e);
    tick();
    req = 1'b0;
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0; req = 1'b0; write = 1'b0; par_inj = 1'b0;
    ready_edge = NEVER;
    q.delete();
    repeat (3) tick();
  endtask

  task automatic release_reset();
    rst_ni = 1'b1;
    ready_edge = edge_cnt + DEP;
    for (int i = 0; i < DEP; i++) begin
      mem_m[i] = '0;
      par_m[i] = 1'b0;
    end
  endtask

  task automatic wait_init_count(input string name);
    int n;
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (init_done) break;
    end
    checks++;
    if (n !== DEP) begin
      errors++;
      $display("FAIL %s: init_done after %0d cycles, required %0d", name, n, DEP);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; req = 1'b0; write = 1'b0; addr = '0; wdata = '0; par_inj = 1'b0;
    tick();
    mon_en = 1'b1;
    apply_reset();
    checks++;
    if (init_done !== 1'b0 || rvalid !== 1'b0 || rdata !== '0 || rerror !== 2'b00) begin
      errors++;
      $display("FAIL reset_values: init_done=%b rvalid=%b rdata=%h rerror=%b, required 0/0/0/00",
               init_done, rvalid, rdata, rerror);
    end
  endtask

  task automatic test_init();
    release_reset();
    wait_init_count("init_len");
    for (int a = 0; a < DEP; a++) rd(a, 1'b1);
    repeat (4) tick();
  endtask

  task automatic test_write_read();
    wr(3, 32'hDEAD_BEEF, 1'b0);
    rd(3, 1'b1);
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    wr(1, 32'h11, 1'b0);
    wr(2, 32'h22, 1'b0);
    wr(3, 32'h33, 1'b0);
    rd(3, 1'b1);
    rd(1, 1'b1);
    rd(2, 1'b1);
    repeat (4) tick();
  endtask

  task automatic test_parity();
    wr(7, 32'h5, 1'b1);
    rd(7, 1'b1);
    wr(7, 32'h5, 1'b0);
    rd(7, 1'b1);
    wr(9, 32'h8000_0001, 1'b1);
    rd(9, 1'b1);
    repeat (4) tick();
  endtask

  task automatic test_init_read();
    apply_reset();
    release_reset();
    repeat (2) tick();
    rd(0, 1'b1);
    wr(5, 32'hCAFE_F00D, 1'b0);
    rd(6, 1'b1);
    while (edge_cnt < ready_edge) tick();
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done_after_init: init_done=%b, required 1", init_done);
    end
    rd(5, 1'b1);
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    wr(4, 32'h1234_5678, 1'b0);
    rd(4, 1'b0);
    rst_ni = 1'b0;
    ready_edge = NEVER;
    repeat (3) tick();
    checks++;
    if (init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_done: init_done=%b, required 0", init_done);
    end
    release_reset();
    wait_init_count("reinit_len");
    rd(4, 1'b1);
    repeat (4) tick();
  endtask

  task automatic test_random_mix();
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        wr($urandom_range(0, DEP - 1), $urandom, 1'($urandom_range(0, 3) == 0));
      else
        rd($urandom_range(0, DEP - 1), 1'b1);
    end
    repeat (5) tick();
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_back_to_back();
    test_parity();
    test_init_read();
    test_reset_mid();
    test_random_mix();
    checks++;
    if (q.size() !== 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_1p_rsp.md
Name: sram_1p_rsp

Overview:
- Single-port SRAM back-end that sits directly downstream of the N:1 SRAM arbiter.
- Consumes its sram_req/addr/write/wdata bus and drives sram_rvalid/rdata/rerror back.
- Contains the storage array, per-word parity and a post-reset initialisation sequencer.
- Read responses come back in request order with fixed latency, as the arbiter's steering FIFO requires.

Parameters:
- Aw, 12: address width; Depth = 2**Aw words.
- Dw, 32: data width, excluding parity.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, synchronous, active-low.
- req_i  input  1  request strobe; always accepted, no backpressure.
- addr_i  input  Aw  word address.
- write_i  input  1  1 = write, 0 = read.
- wdata_i  input  Dw  write data.
- par_inj_i  input  1  when set with a write, the stored parity bit is inverted (test hook).
- rvalid_o  output  1  one-cycle pulse per read.
- rdata_o  output  Dw  read data, valid only while rvalid_o = 1.
- rerror_o  output  2  bit1 = uncorrectable (parity) error, bit0 = correctable (always 0).
- init_done_o  output  1  array initialisation finished.

Behaviour:
- Storage: Depth x (Dw+1) bits.
  - Stored parity p = ^wdata_i, XORed with par_inj_i.
  - The array is not reset by rst_ni; only the init FSM clears it.
- FSM states: INIT, READY.
  - Reset (rst_ni = 0 at a clock edge) -> INIT, init counter = 0.
  - INIT: each cycle write word[cnt] = 0 with parity 0, then cnt += 1.
  - When cnt == Depth-1 is written -> READY next cycle; INIT lasts exactly Depth cycles.
  - READY persists until the next reset. Reset mid-INIT restarts the counter at 0.
- init_done_o: 0 during reset and INIT; 1 from the first READY cycle.
- Read in READY (req_i = 1, write_i = 0 at edge N):
  - rvalid_o = 1 for exactly the cycle after edge N (latency 1).
  - rdata_o = stored data.
  - rerror_o = {parity mismatch, 1'b0}, where mismatch = (^data != stored p).
- Write in READY:
  - Array is updated at edge N; no rvalid_o.
  - A read to the same address at edge N+1 returns the new data.
- Requests during INIT:
  - Writes are dropped.
  - Reads still produce rvalid_o one cycle later, with rdata_o = 0 and rerror_o = 2'b10.
  - Order and one-response-per-read are preserved.
- Back-to-back reads, one per cycle, produce one rvalid_o per cycle in issue order; there is no internal limit on reads in flight.
- Reset values: rvalid_o = 0, rdata_o = 0, rerror_o = 0, init_done_o = 0.
  - Reads in flight at reset are discarded; no rvalid_o is produced for them.
- rdata_o and rerror_o are driven 0 whenever rvalid_o = 0.
- Addresses always lie within Depth, since addr_i is exactly Aw wide; there is no out-of-range case.

Optional Feature:
- Macro: SRAM_1P_RSP_OUTREG_EN.
- Defined: an extra output register stage on rvalid_o, rdata_o and rerror_o.
  - Read latency becomes 2 cycles; pipelining stays one read per cycle.
  - The INIT dummy responses are also delayed to 2 cycles.
  - Reset clears both pipeline stages.
  - Write-then-read at edges N and N+1 still returns the new data, at cycle N+3.
- Undefined: latency is 1 as described above.

Test Plan:
- Init, Aw = 4:
  - Release reset -> init_done_o rises after exactly 16 cycles.
  - A read of each address 0..15 then returns rdata 0, rerror 2'b00.
- Write/read:
  - Write 0xDEADBEEF to addr 3, then read addr 3 on the next cycle.
  - -> rvalid_o one cycle after the read, rdata 0xDEADBEEF, rerror 2'b00.
- Pipelined reads:
  - Write 0x11, 0x22, 0x33 to addrs 1, 2, 3, then read 3, 1, 2 on consecutive cycles.
  - -> three consecutive rvalid pulses carrying 0x33, 0x11, 0x22.
- Parity injection:
  - Write 0x5 with par_inj_i = 1 to addr 7, then read addr 7 -> rdata 0x5, rerror 2'b10.
  - Rewrite with par_inj_i = 0, then read -> rerror 2'b00.
- Read during INIT:
  - Read addr 0 at cycle 2 after reset release -> rvalid_o at cycle 3, rdata 0, rerror 2'b10.
  - A write during INIT is not visible after init completes.
- Reset mid-operation:
  - Issue a read, then assert rst_ni = 0 on the next edge -> no rvalid_o.
  - init_done_o = 0, and INIT restarts for a full Depth cycles.
  - With SRAM_1P_RSP_OUTREG_EN defined, all latencies above are +1.
